// File: rtl/cpu_checker_feeder.sv
// Two-source round-robin record arbiter: buffers one whole ^...# trace record
// from the granted source, then replays it gap-free to cpu_checker.
module cpu_checker_feeder #(
   parameter int MAX_LEN = 48,
   parameter int MAX_GAP = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [7:0]  req_char0,
   input  logic [7:0]  req_char1,
   output logic [1:0]  req_ready,
   output logic [7:0]  char_out,
   output logic        out_src,
   output logic        rec_start,
   output logic        rec_done,
   output logic        abort,
   output logic [1:0]  abort_code,
   output logic [15:0] drop_cnt,
   output logic        busy
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int GAP_W = $clog2(MAX_GAP + 1);
   localparam logic [7:0] CARET = 8'h5E;
   localparam logic [7:0] HASH  = 8'h23;
   localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, REPLAY} state_t;

   state_t           state, state_n;
   logic [LEN_W-1:0] len, len_n, rd, rd_n;
   logic [GAP_W-1:0] gap, gap_n;
   logic             grant, grant_n, prio, prio_n, win;
   logic [7:0]       char_n;
   logic             src_n, start_n, done_n, abort_n;
   logic [1:0]       code_n;
   logic [15:0]      drop_n;
   logic [16:0]      drop_sum;
   logic [1:0]       cand, other_byte, drops;
   logic [7:0]       gchar;
   logic             wr_en;
   logic [LEN_W-1:0] wr_idx;
   logic [7:0]       wr_data;
   logic [7:0]       rec_buf [MAX_LEN];

   assign cand       = {req_valid[1] && (req_char1 == CARET), req_valid[0] && (req_char0 == CARET)};
   assign other_byte = {req_valid[1] && (req_char1 != CARET), req_valid[0] && (req_char0 != CARET)};
   assign gchar      = grant ? req_char1 : req_char0;
   assign busy       = (state != IDLE);

   always_comb begin
      state_n   = state;
      len_n     = len;
      rd_n      = rd;
      gap_n     = gap;
      grant_n   = grant;
      prio_n    = prio;
      char_n    = 8'h00;
      src_n     = out_src;
      start_n   = 1'b0;
      done_n    = 1'b0;
      abort_n   = 1'b0;
      code_n    = abort_code;
      req_ready = 2'b00;
      drops     = 2'b00;
      wr_en     = 1'b0;
      wr_idx    = len;
      wr_data   = gchar;
      win       = (&cand) ? prio : cand[1];
      case (state)
         IDLE: begin
            req_ready = other_byte;
            drops     = other_byte;
            if (|cand) begin
               req_ready[win] = 1'b1;
               wr_en          = 1'b1;
               wr_idx         = '0;
               wr_data        = CARET;
               len_n          = LEN_W'(1);
               gap_n          = '0;
               grant_n        = win;
               state_n        = COLLECT;
            end
         end
         COLLECT: begin
            req_ready[grant]  = 1'b1;
            req_ready[~grant] = other_byte[~grant];
            drops[~grant]     = other_byte[~grant];
            if (req_valid[grant]) begin
               gap_n = '0;
               if (gchar == HASH) begin
                  wr_en   = 1'b1;
                  len_n   = len + 1'b1;
                  rd_n    = '0;
                  state_n = REPLAY;
               end else if (gchar == CARET) begin
                  wr_en   = 1'b1;
                  wr_idx  = '0;
                  len_n   = LEN_W'(1);
                  abort_n = 1'b1;
                  code_n  = 2'd3;
               end else if (len == LAST_IDX) begin
                  abort_n = 1'b1;
                  code_n  = 2'd2;
                  len_n   = '0;
                  prio_n  = ~prio;
                  state_n = IDLE;
               end else begin
                  wr_en = 1'b1;
                  len_n = len + 1'b1;
               end
            end else if (gap == GAP_LAST) begin
               abort_n = 1'b1;
               code_n  = 2'd1;
               len_n   = '0;
               gap_n   = '0;
               prio_n  = ~prio;
               state_n = IDLE;
            end else begin
               gap_n = gap + 1'b1;
            end
         end
         REPLAY: begin
            char_n  = rec_buf[rd];
            src_n   = grant;
            start_n = (rd == '0);
            if (rd == len - 1'b1) begin
               done_n  = 1'b1;
               rd_n    = '0;
               len_n   = '0;
               prio_n  = ~grant;
               state_n = IDLE;
            end else begin
               rd_n = rd + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Both sources may drop in the same cycle, so the counter can step by two.
   assign drop_sum = {1'b0, drop_cnt} + {16'd0, drops[0]} + {16'd0, drops[1]};
   assign drop_n   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   always_ff @(posedge clk) begin
      if (wr_en) rec_buf[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         len        <= '0;
         rd         <= '0;
         gap        <= '0;
         grant      <= 1'b0;
         prio       <= 1'b0;
         char_out   <= 8'h00;
         out_src    <= 1'b0;
         rec_start  <= 1'b0;
         rec_done   <= 1'b0;
         abort      <= 1'b0;
         abort_code <= 2'd0;
         drop_cnt   <= 16'd0;
      end else begin
         state      <= state_n;
         len        <= len_n;
         rd         <= rd_n;
         gap        <= gap_n;
         grant      <= grant_n;
         prio       <= prio_n;
         char_out   <= char_n;
         out_src    <= src_n;
         rec_start  <= start_n;
         rec_done   <= done_n;
         abort      <= abort_n;
         abort_code <= code_n;
         drop_cnt   <= drop_n;
      end
   end
endmodule

// File: tb/tb_cpu_checker_feeder.sv
// Directed self-checking bench for cpu_checker_feeder: replay, arbitration,
// timeout/overflow/restart aborts, drop counting and mid-replay reset.
module tb_cpu_checker_feeder;
   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [7:0]  req_char0;
   logic [7:0]  req_char1;
   logic [1:0]  req_ready;
   logic [7:0]  char_out;
   logic        out_src;
   logic        rec_start;
   logic        rec_done;
   logic        abort;
   logic [1:0]  abort_code;
   logic [15:0] drop_cnt;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int errs;
   logic [1:0] last_ready;
   logic [7:0] cap_data  [64];
   logic       cap_start [64];
   logic       cap_done  [64];
   logic       cap_src   [64];
   logic [1:0] cap_ready [64];

   cpu_checker_feeder #(.MAX_LEN(48), .MAX_GAP(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid),
      .req_char0(req_char0), .req_char1(req_char1), .req_ready(req_ready),
      .char_out(char_out), .out_src(out_src), .rec_start(rec_start),
      .rec_done(rec_done), .abort(abort), .abort_code(abort_code),
      .drop_cnt(drop_cnt), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic peek(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1);
      req_valid = v;
      req_char0 = c0;
      req_char1 = c1;
      #1;
      last_ready = req_ready;
   endtask

   task automatic tick(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1);
      peek(v, c0, c1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int src, input string s);
      for (int i = 0; i < s.len(); i++) begin
         if (src == 0) tick(2'b01, s[i], 8'h00);
         else          tick(2'b10, 8'h00, s[i]);
      end
      req_valid = 2'b00;
   endtask

   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         cap_data[k]  = char_out;
         cap_start[k] = rec_start;
         cap_done[k]  = rec_done;
         cap_src[k]   = out_src;
         cap_ready[k] = req_ready;
      end
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      req_valid = 2'b00;
      req_char0 = 8'h00;
      req_char1 = 8'h00;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req_valid = 2'b00;
      req_char0 = 8'h00;
      req_char1 = 8'h00;
      #1;
      tests++;
      if (char_out !== 8'h00 || out_src !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_out: char=%h src=%b busy=%b, required 00/0/0", char_out, out_src, busy);
      end
      tests++;
      if (rec_start !== 1'b0 || rec_done !== 1'b0 || abort !== 1'b0 || abort_code !== 2'd0) begin
         fails++;
         $display("[TB] FAIL reset_pulses: start=%b done=%b abort=%b code=%0d, required all 0",
                  rec_start, rec_done, abort, abort_code);
      end
      tests++;
      if (drop_cnt !== 16'd0 || req_ready !== 2'b00) begin
         fails++;
         $display("[TB] FAIL reset_cnt: drop=%0d ready=%b, required 0/00", drop_cnt, req_ready);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_single_record();
      string s;
      int L;
      s = "^2@ee2a8ee8: *1643b629<= 79fd1df4#";
      L = s.len();
      send(0, s);
      capture(L + 1);
      errs = 0;
      for (int k = 0; k <= L; k++) begin
         if (cap_data[k] !== ((k < L) ? s[k] : 8'h00)) errs++;
         if (cap_start[k] !== (k == 0)) errs++;
         if (cap_done[k] !== (k == L - 1)) errs++;
         if (k < L && cap_src[k] !== 1'b0) errs++;
      end
      tests++;
      if (errs != 0) begin
         fails++;
         $display("[TB] FAIL replay_34: %0d byte/flag errors, required 0", errs);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL busy_after_replay: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_arbitration();
      string s0, s1;
      s0 = "^AB#";
      s1 = "^CD#";
      apply_reset();
      peek(2'b11, 8'h5E, 8'h5E);
      tests++;
      if (last_ready !== 2'b01) begin
         fails++;
         $display("[TB] FAIL arb_grant: ready=%b, required 01", last_ready);
      end
      @(posedge clk);
      #1;
      for (int i = 1; i < 4; i++) tick(2'b11, s0[i], 8'h5E);
      tests++;
      if (last_ready !== 2'b01) begin
         fails++;
         $display("[TB] FAIL arb_stall: ready=%b, required 01", last_ready);
      end
      req_valid = 2'b10;
      capture(5);
      errs = 0;
      for (int k = 0; k <= 4; k++) begin
         if (cap_data[k] !== ((k < 4) ? s0[k] : 8'h00)) errs++;
         if (k < 4 && cap_src[k] !== 1'b0) errs++;
      end
      tests++;
      if (errs != 0 || cap_ready[0] !== 2'b00 || cap_ready[3] !== 2'b10) begin
         fails++;
         $display("[TB] FAIL arb_first: errs=%0d ready0=%b ready3=%b, required 0/00/10",
                  errs, cap_ready[0], cap_ready[3]);
      end
      for (int i = 1; i < 4; i++) tick(2'b10, 8'h00, s1[i]);
      req_valid = 2'b00;
      capture(5);
      errs = 0;
      for (int k = 0; k <= 4; k++) begin
         if (cap_data[k] !== ((k < 4) ? s1[k] : 8'h00)) errs++;
         if (k < 4 && cap_src[k] !== 1'b1) errs++;
         if (cap_start[k] !== (k == 0) || cap_done[k] !== (k == 3)) errs++;
      end
      tests++;
      if (errs != 0) begin
         fails++;
         $display("[TB] FAIL arb_second: %0d errors, required 0", errs);
      end
      peek(2'b11, 8'h5E, 8'h5E);
      tests++;
      if (last_ready !== 2'b01) begin
         fails++;
         $display("[TB] FAIL arb_prio_end: ready=%b, required 01", last_ready);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_timeout();
      string s;
      s = "^xy#";
      apply_reset();
      send(1, "^9@88b7");
      errs = 0;
      for (int i = 0; i < 15; i++) begin
         tick(2'b00, 8'h00, 8'h00);
         if (abort !== 1'b0 || busy !== 1'b1 || char_out !== 8'h00) errs++;
      end
      tick(2'b00, 8'h00, 8'h00);
      tests++;
      if (errs != 0 || abort !== 1'b1 || abort_code !== 2'd1 || busy !== 1'b0 || char_out !== 8'h00) begin
         fails++;
         $display("[TB] FAIL gap_timeout: errs=%0d abort=%b code=%0d busy=%b, required 0/1/1/0",
                  errs, abort, abort_code, busy);
      end
      tick(2'b00, 8'h00, 8'h00);
      tests++;
      if (abort !== 1'b0 || abort_code !== 2'd1) begin
         fails++;
         $display("[TB] FAIL abort_pulse: abort=%b code=%0d, required 0/1", abort, abort_code);
      end
      send(0, s);
      capture(5);
      errs = 0;
      for (int k = 0; k < 4; k++) if (cap_data[k] !== s[k] || cap_src[k] !== 1'b0) errs++;
      tests++;
      if (errs != 0) begin
         fails++;
         $display("[TB] FAIL after_timeout: %0d errors, required 0", errs);
      end
   endtask

   task automatic test_overflow_restart();
      string s;
      int L;
      apply_reset();
      tick(2'b01, 8'h5E, 8'h00);
      for (int i = 0; i < 46; i++) tick(2'b01, 8'h61, 8'h00);
      tests++;
      if (abort !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL pre_overflow: abort=%b busy=%b, required 0/1", abort, busy);
      end
      tick(2'b01, 8'h61, 8'h00);
      tests++;
      if (abort !== 1'b1 || abort_code !== 2'd2 || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL overflow: abort=%b code=%0d busy=%b, required 1/2/0", abort, abort_code, busy);
      end
      tick(2'b01, 8'h5E, 8'h00);
      tick(2'b01, 8'h61, 8'h00);
      tick(2'b01, 8'h5E, 8'h00);
      tests++;
      if (abort !== 1'b1 || abort_code !== 2'd3 || busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL restart: abort=%b code=%0d busy=%b, required 1/3/1", abort, abort_code, busy);
      end
      send(0, "b#");
      capture(4);
      tests++;
      if (cap_data[0] !== 8'h5E || cap_data[1] !== 8'h62 || cap_data[2] !== 8'h23 || cap_data[3] !== 8'h00) begin
         fails++;
         $display("[TB] FAIL restart_replay: got %h %h %h %h, required 5e 62 23 00",
                  cap_data[0], cap_data[1], cap_data[2], cap_data[3]);
      end
      s = "^";
      for (int i = 0; i < 46; i++) s = {s, "m"};
      s = {s, "#"};
      L = s.len();
      send(0, s);
      capture(L + 1);
      errs = 0;
      for (int k = 0; k <= L; k++) begin
         if (cap_data[k] !== ((k < L) ? s[k] : 8'h00)) errs++;
         if (cap_done[k] !== (k == L - 1)) errs++;
      end
      tests++;
      if (errs != 0) begin
         fails++;
         $display("[TB] FAIL max_len_replay: %0d errors over %0d bytes, required 0", errs, L);
      end
   endtask

   task automatic test_drops();
      string s;
      s = "^pq#";
      apply_reset();
      tick(2'b01, 8'h78, 8'h00);
      tick(2'b01, 8'h79, 8'h00);
      tests++;
      if (drop_cnt !== 16'd2 || last_ready !== 2'b01) begin
         fails++;
         $display("[TB] FAIL drop_idle: drop=%0d ready=%b, required 2/01", drop_cnt, last_ready);
      end
      tick(2'b11, 8'h6D, 8'h6E);
      tests++;
      if (drop_cnt !== 16'd4) begin
         fails++;
         $display("[TB] FAIL drop_both: drop=%0d, required 4", drop_cnt);
      end
      tick(2'b01, 8'h5E, 8'h00);
      tick(2'b11, 8'h70, 8'h7A);
      tests++;
      if (drop_cnt !== 16'd5 || last_ready !== 2'b11) begin
         fails++;
         $display("[TB] FAIL drop_collect: drop=%0d ready=%b, required 5/11", drop_cnt, last_ready);
      end
      tick(2'b01, 8'h71, 8'h00);
      tick(2'b01, 8'h23, 8'h00);
      req_valid = 2'b00;
      capture(5);
      errs = 0;
      for (int k = 0; k <= 4; k++) if (cap_data[k] !== ((k < 4) ? s[k] : 8'h00)) errs++;
      tests++;
      if (errs != 0) begin
         fails++;
         $display("[TB] FAIL drop_replay: %0d errors, required 0", errs);
      end
   endtask

   task automatic test_back_to_back();
      string s;
      s = "^ab#";
      send(0, s);
      capture(4);
      tick(2'b01, 8'h5E, 8'h00);
      tests++;
      if (last_ready !== 2'b01 || cap_done[3] !== 1'b1) begin
         fails++;
         $display("[TB] FAIL b2b_accept: ready=%b done=%b, required 01/1", last_ready, cap_done[3]);
      end
      send(0, "c#");
      capture(4);
      tests++;
      if (cap_data[0] !== 8'h5E || cap_data[1] !== 8'h63 || cap_data[2] !== 8'h23 || cap_start[0] !== 1'b1) begin
         fails++;
         $display("[TB] FAIL b2b_second: got %h %h %h start=%b, required 5e 63 23 1",
                  cap_data[0], cap_data[1], cap_data[2], cap_start[0]);
      end
   endtask

   task automatic test_reset_mid_replay();
      string s;
      s = "^0123456789abcdefgh#";
      send(0, s);
      capture(5);
      tests++;
      if (cap_data[4] !== s[4] || busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL mid_replay: char=%h busy=%b, required %h/1", cap_data[4], busy, s[4]);
      end
      reset = 1'b0;
      #1;
      tests++;
      if (char_out !== 8'h00 || busy !== 1'b0 || rec_done !== 1'b0 || rec_start !== 1'b0) begin
         fails++;
         $display("[TB] FAIL async_reset: char=%h busy=%b done=%b, required 00/0/0", char_out, busy, rec_done);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      s = "^ok#";
      send(0, s);
      capture(5);
      errs = 0;
      for (int k = 0; k <= 4; k++) if (cap_data[k] !== ((k < 4) ? s[k] : 8'h00)) errs++;
      tests++;
      if (errs != 0) begin
         fails++;
         $display("[TB] FAIL post_reset_replay: %0d errors, required 0", errs);
      end
   endtask

   initial begin
      test_reset();
      test_single_record();
      test_arbitration();
      test_timeout();
      test_overflow_restart();
      test_drops();
      test_back_to_back();
      test_reset_mid_replay();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
